// File: rtl/sharpx1_ioctl_upload.sv
// ---------------------------------------------------------------------------
// sharpx1_ioctl_upload
//
// Upload (save) side of the hps_io ioctl link. A host read strobe is turned
// into a req/ack memory fetch on a core memory port (dpram port B or a
// Z80-side arbiter); the fetched byte is presented on ioctl_din while
// ioctl_wait holds the host off. Unmatched, out-of-range and timed-out reads
// return FILL without (or after abandoning) a memory access.
//
// Optional feature macro: SHARPX1_UPLOAD_CSUM_EN
//   Adds upload_sum/upload_cnt, a running 16-bit byte sum and a saturating
//   count of every byte latched into ioctl_din during the current session.
//
// Ports
//   clk_sys       in   system clock, rising edge
//   reset_n       in   synchronous reset, active low
//   ioctl_upload  in   host upload session active
//   ioctl_index   in   session index (matched against INDEX)
//   ioctl_rd      in   one-cycle read strobe
//   ioctl_addr    in   byte address, valid with ioctl_rd
//   ioctl_din     out  read data to host
//   ioctl_wait    out  high while a read is pending
//   upload_size   in   number of valid bytes
//   mem_addr      out  memory address, stable while mem_req is high
//   mem_req       out  memory request, held until mem_ack
//   mem_ack       in   one-cycle grant
//   mem_q         in   memory data, valid RD_LAT cycles after mem_ack
//   busy          out  FSM not idle
//   err           out  sticky timeout / overlapping-read flag
//   upload_sum    out  (CSUM only) sum of latched bytes mod 2^16
//   upload_cnt    out  (CSUM only) saturating count of latched bytes
// ---------------------------------------------------------------------------
module sharpx1_ioctl_upload #(
   parameter int unsigned AW      = 16,
   parameter logic [7:0]  INDEX   = 8'h01,
   parameter int unsigned RD_LAT  = 1,
   parameter logic [7:0]  FILL    = 8'hFF,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          ioctl_upload,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_rd,
   input  logic [24:0]   ioctl_addr,
   output logic [7:0]    ioctl_din,
   output logic          ioctl_wait,
   input  logic [AW:0]   upload_size,
   output logic [AW-1:0] mem_addr,
   output logic          mem_req,
   input  logic          mem_ack,
   input  logic [7:0]    mem_q,
`ifdef SHARPX1_UPLOAD_CSUM_EN
   output logic [15:0]   upload_sum,
   output logic [AW:0]   upload_cnt,
`endif
   output logic          busy,
   output logic          err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_LAT,
      S_HOLD
   } state_t;

   state_t        state, state_d;
   logic [7:0]    din_d;
   logic          wait_d;
   logic          req_d;
   logic [AW-1:0] addr_d;
   logic          err_d;
   logic [7:0]    to_cnt, to_d;
   logic [2:0]    lat_cnt, lat_d;
   logic          abort, abort_d;
   logic          upload_q;

   logic          upload_rise;
   logic          addr_ok;
   logic          rd_hit;
   logic          latch;        // a byte is being written into ioctl_din

   assign upload_rise = ioctl_upload & ~upload_q;

   // Address must fit the memory port and lie below the valid size.
   assign addr_ok = ((ioctl_addr >> AW) == '0) &&
                    (32'(ioctl_addr) < 32'(upload_size));
   assign rd_hit  = (ioctl_index == INDEX) && addr_ok;

   assign busy = (state != S_IDLE);

   always_comb begin
      state_d = state;
      din_d   = ioctl_din;
      wait_d  = ioctl_wait;
      req_d   = mem_req;
      addr_d  = mem_addr;
      err_d   = err;
      to_d    = to_cnt;
      lat_d   = lat_cnt;
      abort_d = abort;
      latch   = 1'b0;

      if (upload_rise)
         err_d = 1'b0;
      if (ioctl_rd && (state != S_IDLE))
         err_d = 1'b1;

      case (state)
         S_IDLE: begin
            if (ioctl_rd && ioctl_upload) begin
               if (rd_hit) begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  wait_d  = 1'b1;
                  addr_d  = ioctl_addr[AW-1:0];
                  to_d    = '0;
                  abort_d = 1'b0;
               end else begin
                  din_d = FILL;
                  latch = 1'b1;
               end
            end
         end

         S_REQ: begin
            // A session drop is remembered but the handshake is still
            // completed so the arbiter never sees a withdrawn request.
            if (!ioctl_upload)
               abort_d = 1'b1;
            if (mem_ack) begin
               req_d = 1'b0;
               if (abort_d) begin
                  state_d = S_IDLE;
                  wait_d  = 1'b0;
               end else begin
                  lat_d   = 3'(RD_LAT);
                  state_d = S_LAT;
               end
            end else if (to_cnt == 8'(TIMEOUT - 1)) begin
               req_d   = 1'b0;
               din_d   = FILL;
               latch   = 1'b1;
               err_d   = 1'b1;
               state_d = S_HOLD;
            end else begin
               to_d = to_cnt + 8'd1;
            end
         end

         S_LAT: begin
            if (!ioctl_upload)
               abort_d = 1'b1;
            if (lat_cnt <= 3'd1) begin
               if (abort_d) begin
                  state_d = S_IDLE;
                  wait_d  = 1'b0;
               end else begin
                  din_d   = mem_q;
                  latch   = 1'b1;
                  state_d = S_HOLD;
               end
            end else begin
               lat_d = lat_cnt - 3'd1;
            end
         end

         S_HOLD: begin
            // ioctl_din was updated on entry; wait drops one cycle later so
            // the host never samples data in the same cycle it changes.
            wait_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         ioctl_din  <= FILL;
         ioctl_wait <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         err        <= 1'b0;
         to_cnt     <= '0;
         lat_cnt    <= '0;
         abort      <= 1'b0;
         upload_q   <= 1'b0;
      end else begin
         state      <= state_d;
         ioctl_din  <= din_d;
         ioctl_wait <= wait_d;
         mem_req    <= req_d;
         mem_addr   <= addr_d;
         err        <= err_d;
         to_cnt     <= to_d;
         lat_cnt    <= lat_d;
         abort      <= abort_d;
         upload_q   <= ioctl_upload;
      end
   end

`ifdef SHARPX1_UPLOAD_CSUM_EN
   logic [15:0] sum_d;
   logic [AW:0] cnt_d;

   always_comb begin
      sum_d = upload_rise ? '0 : upload_sum;
      cnt_d = upload_rise ? '0 : upload_cnt;
      if (latch) begin
         sum_d = sum_d + {8'h00, din_d};
         if (cnt_d != '1)
            cnt_d = cnt_d + 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         upload_sum <= '0;
         upload_cnt <= '0;
      end else begin
         upload_sum <= sum_d;
         upload_cnt <= cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_sharpx1_ioctl_upload.sv
// ---------------------------------------------------------------------------
// tb_sharpx1_ioctl_upload
//
// Self-checking bench for sharpx1_ioctl_upload. A behavioural memory
// responder acks after a chosen delay and presents data RD_LAT cycles after
// the ack (garbage otherwise). Expected results come from the read rules:
// a read hits only with matching index, live session and address below both
// the size and the memory range; hits return mem[addr] after 2+RD_LAT+delay
// wait cycles, misses return FILL with no wait and no memory request.
// ---------------------------------------------------------------------------
module tb_sharpx1_ioctl_upload;

   localparam int unsigned AW      = 16;
   localparam int unsigned RD_LAT  = 1;
   localparam int unsigned TIMEOUT = 10;
   localparam logic [7:0]  INDEX   = 8'h01;
   localparam logic [7:0]  FILL    = 8'hFF;

   logic          clk_sys = 1'b0;
   logic          reset_n;
   logic          ioctl_upload;
   logic [7:0]    ioctl_index;
   logic          ioctl_rd;
   logic [24:0]   ioctl_addr;
   logic [7:0]    ioctl_din;
   logic          ioctl_wait;
   logic [AW:0]   upload_size;
   logic [AW-1:0] mem_addr;
   logic          mem_req;
   logic          mem_ack;
   logic [7:0]    mem_q;
   logic          busy;
   logic          err;
`ifdef SHARPX1_UPLOAD_CSUM_EN
   logic [15:0]   upload_sum;
   logic [AW:0]   upload_cnt;
`endif

   always #5 clk_sys = ~clk_sys;

   sharpx1_ioctl_upload #(
      .AW      (AW),
      .INDEX   (INDEX),
      .RD_LAT  (RD_LAT),
      .FILL    (FILL),
      .TIMEOUT (TIMEOUT)
   ) dut (
`ifdef SHARPX1_UPLOAD_CSUM_EN
      .upload_sum   (upload_sum),
      .upload_cnt   (upload_cnt),
`endif
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .ioctl_upload (ioctl_upload),
      .ioctl_index  (ioctl_index),
      .ioctl_rd     (ioctl_rd),
      .ioctl_addr   (ioctl_addr),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .upload_size  (upload_size),
      .mem_addr     (mem_addr),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .mem_q        (mem_q),
      .busy         (busy),
      .err          (err)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   logic [7:0]    mem [0:65535];
   int unsigned   ack_dly   = 0;
   bit            ack_en    = 1'b1;
   int unsigned   wcnt      = 0;
   bit            acked     = 1'b0;
   int unsigned   qcnt      = 0;
   logic [7:0]    qdata     = '0;
   logic [AW-1:0] req_addr  = '0;
   int unsigned   req_rises = 0;
   int unsigned   req_len   = 0;
   logic          req_prev  = 1'b0;

   initial begin
      mem_ack = 1'b0;
      mem_q   = '0;
      forever begin
         @(negedge clk_sys);
         mem_ack = 1'b0;
         if (qcnt > 0) begin
            qcnt--;
            mem_q = (qcnt == 0) ? qdata : 8'($urandom);
         end else begin
            mem_q = 8'($urandom);
         end
         if (mem_req && !req_prev) begin
            req_rises++;
            req_len  = 0;
            req_addr = mem_addr;
         end
         if (mem_req)
            req_len++;
         req_prev = mem_req;
         if (!mem_req) begin
            acked = 1'b0;
            wcnt  = 0;
         end else if (ack_en && !acked) begin
            if (wcnt >= ack_dly) begin
               mem_ack = 1'b1;
               acked   = 1'b1;
               qcnt    = RD_LAT;
               qdata   = mem[mem_addr];
            end else begin
               wcnt++;
            end
         end
      end
   end

   // ---------------- host-side read ----------------
   task automatic do_read(input logic [24:0] addr, output logic [7:0] din,
                          output int unsigned wcyc);
      @(negedge clk_sys);
      ioctl_rd   = 1'b1;
      ioctl_addr = addr;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      wcyc = 0;
      while (ioctl_wait === 1'b1 && wcyc < 400) begin
         wcyc++;
         @(negedge clk_sys);
      end
      #1;
      din = ioctl_din;
   endtask

   task automatic toggle_upload();
      @(negedge clk_sys);
      ioctl_upload = 1'b0;
      @(negedge clk_sys);
      ioctl_upload = 1'b1;
      @(negedge clk_sys);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_din"},  32'(ioctl_din),  32'(FILL));
      chk({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
      chk({tag, "_req"},  32'(mem_req),    32'd0);
      chk({tag, "_addr"}, 32'(mem_addr),   32'd0);
      chk({tag, "_busy"}, 32'(busy),       32'd0);
      chk({tag, "_err"},  32'(err),        32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  din, prev;
      int unsigned wcyc, rises0, kind;
      logic [24:0] addr;
      logic [7:0]  idx;
      bit          hit, exp_err;
      logic [7:0]  exp_din;

      for (int i = 0; i < 65536; i++)
         mem[i] = 8'($urandom);

      reset_n      = 1'b0;
      ioctl_upload = 1'b1;
      ioctl_index  = INDEX;
      ioctl_rd     = 1'b0;
      ioctl_addr   = '0;
      upload_size  = 17'd16;
      repeat (3) @(negedge clk_sys);
      #1;
      chk_reset_vals("reset");
      reset_n = 1'b1;
      exp_err = 1'b0;

      // basic hit, first-cycle ack
      mem[5]  = 8'hA5;
      ack_dly = 0;
      rises0  = req_rises;
      do_read(25'd5, din, wcyc);
      chk("t1_din",     32'(din),       32'hA5);
      chk("t1_wait",    wcyc,           2 + RD_LAT);
      chk("t1_memaddr", 32'(req_addr),  32'd5);
      chk("t1_rises",   req_rises,      rises0 + 1);
      chk("t1_err",     32'(err),       32'd0);

      // out of range
      rises0 = req_rises;
      do_read(25'd16, din, wcyc);
      chk("t2_din",   32'(din), 32'(FILL));
      chk("t2_wait",  wcyc,     0);
      chk("t2_rises", req_rises, rises0);

      // wrong index, then matching index
      ioctl_index = 8'h02;
      rises0 = req_rises;
      do_read(25'd5, din, wcyc);
      chk("t3_din",   32'(din), 32'(FILL));
      chk("t3_wait",  wcyc,     0);
      chk("t3_rises", req_rises, rises0);
      ioctl_index = INDEX;
      do_read(25'd5, din, wcyc);
      chk("t3_din_ok", 32'(din), 32'hA5);

      // timeout
      ack_en = 1'b0;
      do_read(25'd3, din, wcyc);
      #1;
      chk("t4_din",    32'(din),    32'(FILL));
      chk("t4_reqlen", req_len,     TIMEOUT);
      chk("t4_wait",   wcyc,        TIMEOUT + 1);
      chk("t4_err",    32'(err),    32'd1);
      ack_en = 1'b1;
      toggle_upload();
      chk("t4_errclr", 32'(err), 32'd0);

      // overlapping read during REQ
      ack_dly = 3;
      @(negedge clk_sys);
      ioctl_rd = 1'b1; ioctl_addr = 25'd7;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      @(negedge clk_sys);
      ioctl_rd = 1'b1; ioctl_addr = 25'd9;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      wcyc = 0;
      while (ioctl_wait === 1'b1 && wcyc < 400) begin
         wcyc++;
         @(negedge clk_sys);
      end
      #1;
      chk("t5_din",     32'(ioctl_din), 32'(mem[7]));
      chk("t5_err",     32'(err),       32'd1);
      chk("t5_memaddr", 32'(req_addr),  32'd7);
      toggle_upload();
      chk("t5_errclr", 32'(err), 32'd0);

      // session drop during REQ: handshake still completes, data discarded
      prev = ioctl_din;
      @(negedge clk_sys);
      ioctl_rd = 1'b1; ioctl_addr = 25'd8;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      ioctl_upload = 1'b0;
      wcyc = 0;
      while ((ioctl_wait === 1'b1 || mem_req === 1'b1) && wcyc < 400) begin
         wcyc++;
         @(negedge clk_sys);
      end
      @(negedge clk_sys);
      #1;
      chk("t5b_reqlen", req_len,         ack_dly + 1);
      chk("t5b_busy",   32'(busy),       32'd0);
      chk("t5b_wait",   32'(ioctl_wait), 32'd0);
      chk("t5b_din",    32'(ioctl_din),  32'(prev));
      ioctl_upload = 1'b1;
      @(negedge clk_sys);

      // reset while a request is outstanding
      ack_en = 1'b0;
      @(negedge clk_sys);
      ioctl_rd = 1'b1; ioctl_addr = 25'd2;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      @(negedge clk_sys);
      chk("t6_reqhi", 32'(mem_req), 32'd1);
      reset_n = 1'b0;
      @(negedge clk_sys);
      #1;
      chk_reset_vals("t6_rst");
      reset_n = 1'b1;
      ack_en  = 1'b1;
      exp_err = 1'b0;

`ifdef SHARPX1_UPLOAD_CSUM_EN
      toggle_upload();
      mem[0] = 8'h01;
      mem[1] = 8'h02;
      upload_size = 17'd16;
      do_read(25'd0, din, wcyc);
      do_read(25'd1, din, wcyc);
      do_read(25'd20, din, wcyc);
      chk("csum_sum", 32'(upload_sum), 32'h0102);
      chk("csum_cnt", 32'(upload_cnt), 32'd3);
`endif

      // randomized reads against the rule-based model
      exp_din = ioctl_din;
      for (int it = 0; it < 60; it++) begin
         ack_dly = $urandom_range(0, 3);
         kind    = $urandom_range(0, 9);
         idx     = INDEX;
         upload_size = 17'($urandom_range(0, 40));
         addr    = 25'($urandom_range(0, 44));
         if (kind == 1) idx = 8'($urandom_range(2, 255));
         if (kind == 2) begin
            upload_size = 17'h1FFFF;
            addr = 25'h10000 + 25'($urandom_range(0, 255));
         end
         if (kind == 3) begin
            upload_size = 17'h1FFFF;
            addr = 25'($urandom_range(0, 65535));
         end
         if (kind == 5) addr = 25'h1000000 | addr;
         if (kind == 6) upload_size = '0;
         ioctl_index = idx;
         if (kind == 4) ioctl_upload = 1'b0;

         hit = ioctl_upload && (idx == INDEX) &&
               (32'(addr) < 32'(upload_size)) && (32'(addr) < (32'd1 << AW));
         if (hit)
            exp_din = mem[addr[15:0]];
         else if (ioctl_upload)
            exp_din = FILL;

         rises0 = req_rises;
         do_read(addr, din, wcyc);
         #1;
         chk("rnd_din",   32'(din),   32'(exp_din));
         chk("rnd_wait",  wcyc,       hit ? (2 + RD_LAT + ack_dly) : 0);
         chk("rnd_rises", req_rises,  rises0 + (hit ? 1 : 0));
         if (hit)
            chk("rnd_memaddr", 32'(req_addr), 32'(addr[15:0]));
         chk("rnd_busy", 32'(busy), 32'd0);
         if (kind == 4) begin
            ioctl_upload = 1'b1;
            @(negedge clk_sys);
            #1;
            exp_err = 1'b0;
         end
         chk("rnd_err", 32'(err), 32'(exp_err));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
